des_link_host: RTL and testbench

Host-side end of the DES byte-serial link. It takes a 64-bit block, sends it as eight LSB-first serial bytes to the DES serial adapter, and collects the eight serial result bytes the adapter sends back into a 64-bit result. It sits between the host/testbench block interface and the adapter's `sin`/`sout` pins, and owns the frame phase of the link.

---
 rtl/des_link_host.sv | 126 ++++++++++++
 tb/tb_des_link_host.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_link_host.sv
// Host end of the DES byte-serial link: sends a 64-bit block as eight LSB-first
// serial bytes and gathers the eight returned bytes into a 64-bit result.
module des_link_host #(
   parameter int unsigned RX_LAT = 2
) (
   input  logic        clk,
   input  logic        en,
   input  logic [63:0] blk_in,
   input  logic        blk_valid,
   output logic        blk_ready,
   output logic        sout,
   input  logic        sin,
   output logic [63:0] res,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [2:0]  slot
);

   localparam int unsigned F_W = 5;
   localparam logic [F_W-1:0] F_RX0  = F_W'(RX_LAT);
   localparam logic [F_W-1:0] F_LAST = F_W'(RX_LAT + 7);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ALIGN = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]     state, state_n;
   logic [F_W-1:0] f, f_n;
   logic [63:0]    blk, blk_n;
   logic [63:0]    res_n;
   logic           sout_n, blk_ready_n, res_valid_n;
   logic [2:0]     slot_n, slot_inc;
   logic           run, run_n;
   logic [F_W-1:0] rx, nf;

   // Next-state and next-output logic; run holds slot at 0 for the first cycle out of reset.
   always_comb begin
      state_n     = state;
      f_n         = f;
      blk_n       = blk;
      res_n       = res;
      sout_n      = sout;
      blk_ready_n = blk_ready;
      res_valid_n = res_valid;
      run_n       = 1'b1;
      slot_inc    = slot + 3'd1;
      slot_n      = run ? slot_inc : 3'd0;
      rx          = f - F_RX0;
      nf          = (slot == 3'd7) ? f + F_W'(1) : f;

      case (state)
         S_IDLE: begin
            sout_n      = 1'b1;
            blk_ready_n = 1'b1;
            if (blk_valid && blk_ready) begin
               blk_n       = blk_in;
               blk_ready_n = 1'b0;
               if (slot == 3'd7) begin
                  state_n = S_XFER;
                  f_n     = '0;
                  res_n   = '0;
                  sout_n  = blk_in[0];
               end else begin
                  state_n = S_ALIGN;
               end
            end
         end
         S_ALIGN: begin
            if (slot == 3'd7) begin
               state_n = S_XFER;
               f_n     = '0;
               res_n   = '0;
               sout_n  = blk[0];
            end
         end
         S_XFER: begin
            // rx wraps above 7 before the receive window opens
            if (rx < F_W'(8)) res_n[{rx[2:0], slot}] = sin;
            if (slot == 3'd7 && f == F_LAST) begin
               state_n     = S_DONE;
               res_valid_n = 1'b1;
               sout_n      = 1'b1;
            end else begin
               f_n    = nf;
               sout_n = (nf < F_W'(8)) ? blk[{nf[2:0], slot_inc}] : 1'b1;
            end
         end
         S_DONE: begin
            sout_n = 1'b1;
            if (res_ready) begin
               state_n     = S_IDLE;
               res_valid_n = 1'b0;
               blk_ready_n = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!en) begin
         state     <= S_IDLE;
         f         <= '0;
         blk       <= '0;
         res       <= '0;
         sout      <= 1'b1;
         blk_ready <= 1'b0;
         res_valid <= 1'b0;
         slot      <= 3'd0;
         run       <= 1'b0;
      end else begin
         state     <= state_n;
         f         <= f_n;
         blk       <= blk_n;
         res       <= res_n;
         sout      <= sout_n;
         blk_ready <= blk_ready_n;
         res_valid <= res_valid_n;
         slot      <= slot_n;
         run       <= run_n;
      end
   end

endmodule

// File: tb/tb_des_link_host.sv
// Bench for des_link_host: two loopback instances (RX_LAT=0 and RX_LAT=2) with a
// result scoreboard, alignment/latency checks, backpressure and mid-transfer reset.
module tb_des_link_host;

   logic        clk = 1'b0;
   logic        en, bv, rr, sel2;
   logic [63:0] blk_in;

   logic        ready0, sout0, rv0, ready2, sout2, rv2;
   logic [63:0] res0, res2;
   logic [2:0]  slot0, slot2;
   logic        bv0, bv2, rr0, rr2;

   logic [2:0]  slot_x;
   logic        ready_x, sout_x, rv_x;
   logic [63:0] res_x;

   int nvec = 0;
   int nfail = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   assign bv0 = bv & ~sel2;
   assign bv2 = bv & sel2;
   assign rr0 = sel2 ? 1'b1 : rr;
   assign rr2 = sel2 ? rr : 1'b1;

   assign slot_x  = sel2 ? slot2 : slot0;
   assign ready_x = sel2 ? ready2 : ready0;
   assign sout_x  = sel2 ? sout2 : sout0;
   assign rv_x    = sel2 ? rv2 : rv0;
   assign res_x   = sel2 ? res2 : res0;

   des_link_host #(.RX_LAT(0)) dut0 (
      .clk(clk), .en(en), .blk_in(blk_in), .blk_valid(bv0), .blk_ready(ready0),
      .sout(sout0), .sin(sout0), .res(res0), .res_valid(rv0), .res_ready(rr0),
      .slot(slot0)
   );

   des_link_host #(.RX_LAT(2)) dut2 (
      .clk(clk), .en(en), .blk_in(blk_in), .blk_valid(bv2), .blk_ready(ready2),
      .sout(sout2), .sin(sout2), .res(res2), .res_valid(rv2), .res_ready(rr2),
      .slot(slot2)
   );

   function automatic logic [63:0] model_res(input logic [63:0] b, input int lat);
      logic [63:0] r;
      for (int i = 0; i < 8; i++)
         r[i*8 +: 8] = (i + lat < 8) ? b[(i+lat)*8 +: 8] : 8'hFF;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Waits for the requested slot, hands over a block and checks TX, latency and result.
   task automatic xfer(input logic [63:0] b, input int s);
      int k, first, lat, i;
      logic [63:0] got, exp_r;
      bit idle_bad;
      lat = sel2 ? 2 : 0;
      i = 0;
      while (!(slot_x == 3'(s) && ready_x === 1'b1) && i < 64) begin
         step();
         i++;
      end
      nvec++;
      if (!(slot_x == 3'(s) && ready_x === 1'b1)) begin
         nfail++;
         $display("FAIL hs_wait: slot=%0d ready=%b, required slot=%0d ready=1", slot_x, ready_x, s);
         return;
      end
      blk_in = b;
      bv = 1'b1;
      exp_q.push_back(model_res(b, lat));
      step();
      bv = 1'b0;
      blk_in = ~b;
      k = 1;
      first = 8 - s;
      idle_bad = 1'b0;
      nvec++;
      if (ready_x !== 1'b0) begin
         nfail++;
         $display("FAIL busy_ready: blk_ready=%b, required 0", ready_x);
      end
      while (k < first) begin
         if (sout_x !== 1'b1) idle_bad = 1'b1;
         step();
         k++;
      end
      nvec++;
      if (slot_x !== 3'd0) begin
         nfail++;
         $display("FAIL first_bit_slot: slot=%0d, required 0", slot_x);
      end
      for (int j = 0; j < 64; j++) begin
         got[j] = sout_x;
         step();
         k++;
      end
      nvec++;
      if (got !== b) begin
         nfail++;
         $display("FAIL tx_bits: got %h, required %h", got, b);
      end
      while (rv_x !== 1'b1 && k < first + 8*(lat+8) + 16) begin
         if (sout_x !== 1'b1) idle_bad = 1'b1;
         step();
         k++;
      end
      nvec++;
      if (k != first + 8*(lat+8)) begin
         nfail++;
         $display("FAIL latency: got %0d cycles, required %0d", k, first + 8*(lat+8));
      end
      nvec++;
      if (idle_bad) begin
         nfail++;
         $display("FAIL idle_high: sout went low outside the TX frames, required 1");
      end
      exp_r = exp_q.pop_front();
      nvec++;
      if (res_x !== exp_r || rv_x !== 1'b1) begin
         nfail++;
         $display("FAIL result: res=%h valid=%b, required %h valid=1", res_x, rv_x, exp_r);
      end
   endtask

   task automatic test_reset();
      en = 1'b0;
      bv = 1'b1;
      sel2 = 1'b0;
      repeat (3) step();
      nvec++;
      if (sout0 !== 1'b1 || ready0 !== 1'b0 || rv0 !== 1'b0 || res0 !== 64'd0 || slot0 !== 3'd0) begin
         nfail++;
         $display("FAIL reset_dut0: sout=%b ready=%b valid=%b res=%h slot=%0d, required 1 0 0 0 0",
                  sout0, ready0, rv0, res0, slot0);
      end
      nvec++;
      if (sout2 !== 1'b1 || ready2 !== 1'b0 || rv2 !== 1'b0 || res2 !== 64'd0 || slot2 !== 3'd0) begin
         nfail++;
         $display("FAIL reset_dut2: sout=%b ready=%b valid=%b res=%h slot=%0d, required 1 0 0 0 0",
                  sout2, ready2, rv2, res2, slot2);
      end
      bv = 1'b0;
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         nvec++;
         if (slot0 !== 3'(i) || slot2 !== 3'(i) || ready0 !== 1'b1) begin
            nfail++;
            $display("FAIL release_slot: slot0=%0d slot2=%0d ready=%b, required %0d %0d 1",
                     slot0, slot2, ready0, i, i);
         end
      end
   endtask

   task automatic test_loop0();
      sel2 = 1'b0;
      xfer(64'h0123456789ABCDEF, 3);
      step();
      nvec++;
      if (ready_x !== 1'b1 || rv_x !== 1'b0) begin
         nfail++;
         $display("FAIL turnaround: ready=%b valid=%b, required 1 0", ready_x, rv_x);
      end
   endtask

   task automatic test_loop2();
      sel2 = 1'b1;
      xfer(64'h0123456789ABCDEF, 5);
      step();
   endtask

   task automatic test_align();
      int slots[3] = '{3, 7, 0};
      sel2 = 1'b1;
      foreach (slots[i]) begin
         xfer({$urandom, $urandom}, slots[i]);
         step();
      end
   endtask

   task automatic test_back_to_back();
      sel2 = 1'b0;
      xfer(64'hA5A5_0F0F_3C3C_FF00, 6);
      xfer(64'h8000_0000_0000_0001, 0);
      step();
   endtask

   task automatic test_backpressure();
      logic [63:0] b1, b2, exp_r;
      int s2, k;
      b1 = 64'hDEAD_BEEF_CAFE_F00D;
      b2 = 64'h1357_9BDF_2468_ACE0;
      sel2 = 1'b0;
      rr = 1'b0;
      xfer(b1, 1);
      blk_in = b2;
      bv = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         nvec++;
         if (res_x !== b1 || ready_x !== 1'b0 || sout_x !== 1'b1 || rv_x !== 1'b1) begin
            nfail++;
            $display("FAIL hold: res=%h ready=%b sout=%b valid=%b, required %h 0 1 1",
                     res_x, ready_x, sout_x, rv_x, b1);
         end
      end
      rr = 1'b1;
      step();
      nvec++;
      if (ready_x !== 1'b1 || rv_x !== 1'b0) begin
         nfail++;
         $display("FAIL release: ready=%b valid=%b, required 1 0", ready_x, rv_x);
      end
      s2 = int'(slot_x);
      exp_q.push_back(model_res(b2, 0));
      step();
      bv = 1'b0;
      nvec++;
      if (ready_x !== 1'b0) begin
         nfail++;
         $display("FAIL accept_next: ready=%b, required 0", ready_x);
      end
      k = 1;
      while (rv_x !== 1'b1 && k < 100) begin
         step();
         k++;
      end
      nvec++;
      if (k != (8 - s2) + 64) begin
         nfail++;
         $display("FAIL bp_latency: got %0d cycles, required %0d", k, (8 - s2) + 64);
      end
      exp_r = exp_q.pop_front();
      nvec++;
      if (res_x !== exp_r) begin
         nfail++;
         $display("FAIL bp_result: res=%h, required %h", res_x, exp_r);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int i;
      sel2 = 1'b0;
      i = 0;
      while (!(slot_x == 3'd2 && ready_x === 1'b1) && i < 64) begin
         step();
         i++;
      end
      blk_in = 64'h0123456789ABCDEF;
      bv = 1'b1;
      step();
      bv = 1'b0;
      repeat (6 + 36) step();
      en = 1'b0;
      step();
      nvec++;
      if (sout0 !== 1'b1 || ready0 !== 1'b0 || rv0 !== 1'b0 || res0 !== 64'd0 || slot0 !== 3'd0) begin
         nfail++;
         $display("FAIL mid_reset: sout=%b ready=%b valid=%b res=%h slot=%0d, required 1 0 0 0 0",
                  sout0, ready0, rv0, res0, slot0);
      end
      en = 1'b1;
      repeat (2) step();
      xfer(64'hFFFFFFFF00000000, 4);
      step();
   endtask

   initial begin
      en = 1'b0;
      bv = 1'b0;
      rr = 1'b1;
      sel2 = 1'b0;
      blk_in = '0;
      @(negedge clk);
      test_reset();
      test_loop0();
      test_loop2();
      test_align();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
